// File: rtl/axis_frame_arbiter.sv
// Round-robin, frame-locked AXI-Stream arbiter: one source owns the egress from grant
// until its tlast beat is accepted, with a single registered output stage.
module axis_frame_arbiter #(
    parameter int DATA_SIZE   = 512,
    parameter int NUM_PORTS   = 4,
    parameter int GRANT_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              port_enable,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    output logic [NUM_PORTS-1:0]              s_tready,
    input  logic [NUM_PORTS*DATA_SIZE-1:0]    s_tdata,
    input  logic [NUM_PORTS*DATA_SIZE/8-1:0]  s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [DATA_SIZE-1:0]              m_tdata,
    output logic [DATA_SIZE/8-1:0]            m_tkeep,
    output logic                              m_tlast,
    output logic                              grant_valid,
    output logic [GRANT_WIDTH-1:0]            grant_index,
    output logic [31:0]                       frame_count
);

    localparam int KEEP_SIZE = DATA_SIZE / 8;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSFER = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [GRANT_WIDTH-1:0]   r_last_grant;
    logic [GRANT_WIDTH-1:0]   r_grant_index;
    logic                     r_grant_valid;

    logic                     r_m_tvalid;
    logic [DATA_SIZE-1:0]     r_m_tdata;
    logic [KEEP_SIZE-1:0]     r_m_tkeep;
    logic                     r_m_tlast;
    logic [31:0]              r_frame_count;

    logic [NUM_PORTS-1:0]     w_req;
    logic [2*NUM_PORTS-1:0]   w_req_dbl;
    logic [NUM_PORTS-1:0]     w_rot;
    logic [GRANT_WIDTH:0]     w_shift;
    logic [GRANT_WIDTH:0]     w_sum;
    logic [GRANT_WIDTH-1:0]   w_pick;
    logic                     w_found;

    logic [NUM_PORTS-1:0]     w_grant_onehot;
    logic [NUM_PORTS-1:0]     w_tready;
    logic [DATA_SIZE-1:0]     w_sel_tdata;
    logic [KEEP_SIZE-1:0]     w_sel_tkeep;
    logic                     w_sel_tlast;
    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_frame_end;
    logic                     w_egress_hs;

    // Rotate the request vector so bit j stands for port (last_grant + 1 + j) mod NUM_PORTS.
    assign w_req     = s_tvalid & port_enable;
    assign w_req_dbl = {w_req, w_req};
    assign w_shift   = {1'b0, r_last_grant} + (GRANT_WIDTH+1)'(1);
    assign w_rot     = NUM_PORTS'(w_req_dbl >> w_shift);

    // Scan downward so the lowest rotated position (highest priority) is written last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = w_shift + (GRANT_WIDTH+1)'(j);
                if (w_sum >= (GRANT_WIDTH+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (GRANT_WIDTH+1)'(NUM_PORTS);
                end
                w_pick = w_sum[GRANT_WIDTH-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
            assign w_grant_onehot[gi] = r_grant_valid && (r_grant_index == GRANT_WIDTH'(gi));
        end
    endgenerate

    // AND-OR mux of the granted source's beat.
    always_comb begin
        w_sel_tdata = '0;
        w_sel_tkeep = '0;
        w_sel_tlast = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_onehot[i]) begin
                w_sel_tdata = s_tdata[i*DATA_SIZE +: DATA_SIZE];
                w_sel_tkeep = s_tkeep[i*KEEP_SIZE +: KEEP_SIZE];
                w_sel_tlast = s_tlast[i];
            end
        end
    end

    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_tready    = ((r_state == TRANSFER) && w_out_free) ? w_grant_onehot : '0;
    assign w_accept    = |(s_tvalid & w_tready);
    assign w_frame_end = w_accept && w_sel_tlast;
    assign w_egress_hs = r_m_tvalid && m_tready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_found) w_state_next = TRANSFER;
            TRANSFER: if (w_frame_end) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant  <= GRANT_WIDTH'(NUM_PORTS - 1);
            r_grant_index <= '0;
            r_grant_valid <= 1'b0;
        end else if (r_state == IDLE && w_found) begin
            r_grant_index <= w_pick;
            r_grant_valid <= 1'b1;
        end else if (r_state == TRANSFER && w_frame_end) begin
            r_last_grant  <= r_grant_index;
            r_grant_valid <= 1'b0;
        end
    end

    // The output register keeps presenting the tlast beat after the grant is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_tdata;
            r_m_tkeep  <= w_sel_tkeep;
            r_m_tlast  <= w_sel_tlast;
        end else if (w_egress_hs) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_egress_hs && r_m_tlast) begin
            r_frame_count <= r_frame_count + 32'd1;
        end
    end

    assign s_tready    = w_tready;
    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_m_tdata;
    assign m_tkeep     = r_m_tkeep;
    assign m_tlast     = r_m_tlast;
    assign grant_valid = r_grant_valid;
    assign grant_index = r_grant_index;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: per-port source queues, a cycle-level reference model of the
// arbitration rules, and directed plus randomized scenarios.
module tb_axis_frame_arbiter;

    localparam int DW    = 32;
    localparam int NP    = 4;
    localparam int GW    = 2;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 256;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP-1:0]     port_enable;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              grant_valid;
    logic [GW-1:0]     grant_index;
    logic [31:0]       frame_count;

    axis_frame_arbiter #(.DATA_SIZE(DW), .NUM_PORTS(NP), .GRANT_WIDTH(GW)) dut (
        .clock(clock), .reset(reset), .port_enable(port_enable),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .grant_valid(grant_valid), .grant_index(grant_index), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    // Source queues
    logic [DW-1:0] src_d [NP][DEPTH];
    logic [KW-1:0] src_k [NP][DEPTH];
    logic          src_l [NP][DEPTH];
    int            src_wr [NP];
    int            src_rd [NP];

    // Reference model state
    bit            mdl_busy;
    int            mdl_g;
    int            mdl_last;
    bit            mdl_mv;
    logic [DW-1:0] mdl_md;
    logic [KW-1:0] mdl_mk;
    bit            mdl_ml;
    logic [31:0]   mdl_fc;

    bit tb_mready = 1'b1;
    bit rand_ready = 1'b0;
    bit rand_gaps = 1'b0;
    bit rand_enable = 1'b0;
    int cyc = 0;

    // Egress and grant logs observed from the DUT
    logic [DW-1:0] eg_d [1024];
    bit            eg_l [1024];
    int            eg_c [1024];
    int            eg_n;
    int            gl [256];
    int            gl_n;
    bit            last_gv;

    int n_checks = 0;
    int n_fail = 0;

    function automatic int rr_pick(int last, logic [NP-1:0] req);
        for (int k = 1; k <= NP; k++) begin
            if (req[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit busy_pending();
        bit r = mdl_busy || mdl_mv;
        for (int i = 0; i < NP; i++) begin
            if (src_rd[i] < src_wr[i] && port_enable[i]) r = 1'b1;
        end
        return r;
    endfunction

    task automatic push_beat(int port, logic [DW-1:0] d, bit last);
        src_d[port][src_wr[port]] = d;
        src_k[port][src_wr[port]] = KW'($urandom);
        src_l[port][src_wr[port]] = last;
        src_wr[port]++;
    endtask

    task automatic add_frame(int port, int len, int tag);
        for (int b = 0; b < len; b++) begin
            push_beat(port, {8'(tag), 8'(port), 8'(b), 8'($urandom)}, b == len - 1);
        end
    endtask

    task automatic clear_logs();
        eg_n = 0;
        gl_n = 0;
    endtask

    // One clock: drive at the falling edge, check ready just before the rising edge,
    // step the model, then check registered outputs at the next falling edge.
    task automatic tick();
        logic [NP-1:0] req;
        logic [NP-1:0] exp_ready;
        bit acc;
        bit hs;
        bit was_busy;
        int g;
        for (int i = 0; i < NP; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                s_tvalid[i] = !rand_gaps || ($urandom_range(0, 3) != 0);
                s_tdata[i*DW +: DW] = src_d[i][src_rd[i]];
                s_tkeep[i*KW +: KW] = src_k[i][src_rd[i]];
                s_tlast[i] = src_l[i][src_rd[i]];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i*DW +: DW] = DW'($urandom);
                s_tkeep[i*KW +: KW] = KW'($urandom);
                s_tlast[i] = 1'($urandom_range(0, 1));
            end
            if (rand_enable) port_enable[i] = ($urandom_range(0, 3) != 0);
        end
        m_tready = rand_ready ? ($urandom_range(0, 2) != 0) : tb_mready;
        #4;
        req = s_tvalid & port_enable;
        exp_ready = '0;
        if (mdl_busy && (!mdl_mv || m_tready)) exp_ready[mdl_g] = 1'b1;
        n_checks++;
        if (s_tready !== exp_ready) begin
            n_fail++;
            $display("FAIL s_tready cyc=%0d got=%b exp=%b", cyc, s_tready, exp_ready);
        end
        if (m_tvalid === 1'b1 && m_tready) begin
            eg_d[eg_n] = m_tdata;
            eg_l[eg_n] = m_tlast;
            eg_c[eg_n] = cyc;
            eg_n++;
            $display("egress beat cyc=%0d data=%h keep=%h last=%0b", cyc, m_tdata, m_tkeep, m_tlast);
        end
        hs = mdl_mv && m_tready;
        was_busy = mdl_busy;
        acc = mdl_busy && s_tvalid[mdl_g] && exp_ready[mdl_g];
        if (hs && mdl_ml) mdl_fc++;
        if (acc) begin
            mdl_md = src_d[mdl_g][src_rd[mdl_g]];
            mdl_mk = src_k[mdl_g][src_rd[mdl_g]];
            mdl_ml = src_l[mdl_g][src_rd[mdl_g]];
            mdl_mv = 1'b1;
            if (mdl_ml) begin
                mdl_busy = 1'b0;
                mdl_last = mdl_g;
            end
            src_rd[mdl_g]++;
        end else if (hs) begin
            mdl_mv = 1'b0;
        end
        if (!was_busy) begin
            g = rr_pick(mdl_last, req);
            if (g >= 0) begin
                mdl_busy = 1'b1;
                mdl_g = g;
            end
        end
        @(negedge clock);
        cyc++;
        n_checks++;
        if (m_tvalid !== mdl_mv) begin
            n_fail++;
            $display("FAIL m_tvalid cyc=%0d got=%b exp=%b", cyc, m_tvalid, mdl_mv);
        end
        if (mdl_mv) begin
            n_checks++;
            if (m_tdata !== mdl_md || m_tkeep !== mdl_mk || m_tlast !== mdl_ml) begin
                n_fail++;
                $display("FAIL m_beat cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, m_tdata, m_tkeep, m_tlast,
                         mdl_md, mdl_mk, mdl_ml);
            end
        end
        n_checks++;
        if (grant_valid !== mdl_busy) begin
            n_fail++;
            $display("FAIL grant_valid cyc=%0d got=%b exp=%b", cyc, grant_valid, mdl_busy);
        end
        if (mdl_busy) begin
            n_checks++;
            if (grant_index !== GW'(mdl_g)) begin
                n_fail++;
                $display("FAIL grant_index cyc=%0d got=%0d exp=%0d", cyc, grant_index, mdl_g);
            end
        end
        n_checks++;
        if (frame_count !== mdl_fc) begin
            n_fail++;
            $display("FAIL frame_count cyc=%0d got=%0d exp=%0d", cyc, frame_count, mdl_fc);
        end
        if (grant_valid === 1'b1 && !last_gv) begin
            gl[gl_n] = int'(grant_index);
            gl_n++;
        end
        last_gv = (grant_valid === 1'b1);
    endtask

    task automatic run_until_idle(int budget);
        int c = 0;
        while (c < budget && busy_pending()) begin
            tick();
            c++;
        end
        n_checks++;
        if (busy_pending()) begin
            n_fail++;
            $display("FAIL drain_timeout cyc=%0d got=busy exp=idle within %0d cycles", cyc, budget);
        end
    endtask

    task automatic do_reset(bit check);
        reset = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b1;
        @(negedge clock);
        cyc++;
        if (check) begin
            n_checks++;
            if (m_tvalid !== 1'b0 || grant_valid !== 1'b0 || frame_count !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_ctrl got mv=%b gv=%b fc=%0d exp 0/0/0", m_tvalid, grant_valid, frame_count);
            end
            n_checks++;
            if (s_tready !== '0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0 || grant_index !== '0) begin
                n_fail++;
                $display("FAIL reset_data got rdy=%b d=%h k=%h l=%b gi=%0d exp all 0", s_tready, m_tdata,
                         m_tkeep, m_tlast, grant_index);
            end
        end
        @(negedge clock);
        cyc++;
        reset = 1'b0;
        mdl_busy = 1'b0;
        mdl_g = 0;
        mdl_last = NP - 1;
        mdl_mv = 1'b0;
        mdl_md = '0;
        mdl_mk = '0;
        mdl_ml = 1'b0;
        mdl_fc = '0;
        for (int i = 0; i < NP; i++) src_rd[i] = src_wr[i];
        last_gv = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        repeat (3) tick();
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = DW'('hA1);
        exp_d[1] = DW'('hA2);
        exp_d[2] = DW'('hA3);
        clear_logs();
        for (int b = 0; b < 3; b++) push_beat(1, exp_d[b], b == 2);
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== GW'(1)) begin
            n_fail++;
            $display("FAIL single_grant got gv=%b gi=%0d exp gv=1 gi=1", grant_valid, grant_index);
        end
        run_until_idle(50);
        n_checks++;
        if (eg_n !== 3) begin
            n_fail++;
            $display("FAIL single_count got=%0d exp=3", eg_n);
        end
        for (int b = 0; b < 3 && b < eg_n; b++) begin
            n_checks++;
            if (eg_d[b] !== exp_d[b] || eg_l[b] !== (b == 2)) begin
                n_fail++;
                $display("FAIL single_beat%0d got=%h/%b exp=%h/%b", b, eg_d[b], eg_l[b], exp_d[b], b == 2);
            end
            if (b > 0) begin
                n_checks++;
                if (eg_c[b] - eg_c[b-1] !== 1) begin
                    n_fail++;
                    $display("FAIL single_spacing%0d got=%0d exp=1", b, eg_c[b] - eg_c[b-1]);
                end
            end
        end
        n_checks++;
        if (frame_count !== 32'd1) begin
            n_fail++;
            $display("FAIL single_frame_count got=%0d exp=1", frame_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset(1'b0);
        clear_logs();
        for (int p = 0; p < NP; p++) add_frame(p, 2, 16 + p);
        run_until_idle(100);
        n_checks++;
        if (gl_n !== 4 || eg_n !== 8) begin
            n_fail++;
            $display("FAIL rr_counts got grants=%0d beats=%0d exp 4/8", gl_n, eg_n);
        end
        for (int k = 0; k < 4 && k < gl_n; k++) begin
            n_checks++;
            if (gl[k] !== k) begin
                n_fail++;
                $display("FAIL rr_grant%0d got=%0d exp=%0d", k, gl[k], k);
            end
        end
        for (int k = 0; k < 8 && k < eg_n; k++) begin
            n_checks++;
            if (int'(eg_d[k][23:16]) !== k / 2 || eg_l[k] !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL rr_order%0d got port=%0d last=%b exp port=%0d last=%b", k, eg_d[k][23:16],
                         eg_l[k], k / 2, k % 2 == 1);
            end
        end
        n_checks++;
        if (frame_count !== 32'd4) begin
            n_fail++;
            $display("FAIL rr_frame_count got=%0d exp=4", frame_count);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int c = 0;
        do_reset(1'b0);
        clear_logs();
        base = src_wr[0];
        add_frame(0, 4, 'hB0);
        while (c < 20 && !(eg_n == 1 && m_tvalid === 1'b1)) begin
            tick();
            c++;
        end
        n_checks++;
        if (!(eg_n == 1 && m_tvalid === 1'b1)) begin
            n_fail++;
            $display("FAIL bp_setup got beats=%0d mv=%b exp beats=1 mv=1", eg_n, m_tvalid);
        end
        tb_mready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++;
            if (m_tdata !== src_d[0][base+1] || m_tlast !== 1'b0 || s_tready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got d=%h l=%b rdy=%b exp d=%h l=0 rdy=0", s, m_tdata, m_tlast,
                         s_tready[0], src_d[0][base+1]);
            end
        end
        tb_mready = 1'b1;
        run_until_idle(50);
        n_checks++;
        if (eg_n !== 4) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=4", eg_n);
        end
        for (int k = 0; k < 4 && k < eg_n; k++) begin
            n_checks++;
            if (eg_d[k] !== src_d[0][base+k]) begin
                n_fail++;
                $display("FAIL bp_beat%0d got=%h exp=%h", k, eg_d[k], src_d[0][base+k]);
            end
        end
        n_checks++;
        if (frame_count !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_frame_count got=%0d exp=1", frame_count);
        end
    endtask

    task automatic test_port_enable();
        int base2;
        int c = 0;
        do_reset(1'b0);
        clear_logs();
        port_enable = 4'b0101;
        base2 = src_wr[2];
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < NP; p++) add_frame(p, 3, 32 + f * 4 + p);
        end
        while (c < 200 && (gl_n < 4 || busy_pending())) begin
            if (src_rd[2] == base2 + 4) port_enable[2] = 1'b0;
            tick();
            c++;
        end
        n_checks++;
        if (gl_n !== 4 || eg_n !== 12) begin
            n_fail++;
            $display("FAIL en_counts got grants=%0d beats=%0d exp 4/12", gl_n, eg_n);
        end
        for (int k = 0; k < 4 && k < gl_n; k++) begin
            n_checks++;
            if (gl[k] !== 2 * (k % 2)) begin
                n_fail++;
                $display("FAIL en_grant%0d got=%0d exp=%0d", k, gl[k], 2 * (k % 2));
            end
        end
        if (eg_n > 0) begin
            n_checks++;
            if (eg_d[eg_n-1] !== src_d[2][base2+5] || eg_l[eg_n-1] !== 1'b1) begin
                n_fail++;
                $display("FAIL en_tail got=%h/%b exp=%h/1", eg_d[eg_n-1], eg_l[eg_n-1], src_d[2][base2+5]);
            end
        end
        repeat (3) tick();
        n_checks++;
        if (frame_count !== 32'd4 || gl_n !== 4) begin
            n_fail++;
            $display("FAIL en_final got fc=%0d grants=%0d exp 4/4", frame_count, gl_n);
        end
        for (int i = 0; i < NP; i++) src_rd[i] = src_wr[i];
        port_enable = '1;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int c = 0;
        do_reset(1'b0);
        add_frame(2, 1, 'hC2);
        run_until_idle(20);
        base = src_wr[0];
        add_frame(0, 4, 'hC0);
        while (c < 20 && !(mdl_mv && mdl_md === src_d[0][base+1])) begin
            tick();
            c++;
        end
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== src_d[0][base+1]) begin
            n_fail++;
            $display("FAIL midrst_setup got mv=%b d=%h exp mv=1 d=%h", m_tvalid, m_tdata, src_d[0][base+1]);
        end
        do_reset(1'b1);
        clear_logs();
        add_frame(3, 1, 'hD3);
        add_frame(0, 1, 'hD0);
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== GW'(0)) begin
            n_fail++;
            $display("FAIL midrst_grant got gv=%b gi=%0d exp gv=1 gi=0", grant_valid, grant_index);
        end
        run_until_idle(50);
        n_checks++;
        if (eg_n !== 2 || frame_count !== 32'd2 || eg_d[0][31:24] !== 8'hD0) begin
            n_fail++;
            $display("FAIL midrst_after got beats=%0d fc=%0d tag=%h exp 2/2/d0", eg_n, frame_count, eg_d[0][31:24]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        clear_logs();
        for (int f = 0; f < 4; f++) add_frame(3, 1, 'hE0 + f);
        run_until_idle(50);
        n_checks++;
        if (eg_n !== 4 || frame_count !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_counts got beats=%0d fc=%0d exp 4/4", eg_n, frame_count);
        end
        for (int k = 0; k < 4 && k < eg_n; k++) begin
            n_checks++;
            if (eg_l[k] !== 1'b1 || int'(eg_d[k][23:16]) !== 3) begin
                n_fail++;
                $display("FAIL b2b_beat%0d got last=%b port=%0d exp last=1 port=3", k, eg_l[k], eg_d[k][23:16]);
            end
            if (k > 0) begin
                n_checks++;
                if (eg_c[k] - eg_c[k-1] !== 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d got=%0d exp=2", k, eg_c[k] - eg_c[k-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        int total = 0;
        int c = 0;
        do_reset(1'b0);
        clear_logs();
        for (int f = 0; f < 24; f++) begin
            int p = $urandom_range(0, NP - 1);
            int len = $urandom_range(1, 4);
            add_frame(p, len, f);
            total += len;
        end
        rand_ready = 1'b1;
        rand_gaps = 1'b1;
        rand_enable = 1'b1;
        while (c < 600 && busy_pending()) begin
            tick();
            c++;
        end
        rand_enable = 1'b0;
        port_enable = '1;
        run_until_idle(2000);
        rand_ready = 1'b0;
        rand_gaps = 1'b0;
        n_checks++;
        if (eg_n !== total || frame_count !== 32'd24) begin
            n_fail++;
            $display("FAIL rand_counts got beats=%0d fc=%0d exp %0d/24", eg_n, frame_count, total);
        end
        for (int k = 1; k < eg_n; k++) begin
            if (!eg_l[k-1]) begin
                n_checks++;
                if (eg_d[k][31:16] !== eg_d[k-1][31:16] || eg_d[k][15:8] !== eg_d[k-1][15:8] + 8'd1) begin
                    n_fail++;
                    $display("FAIL rand_interleave%0d got=%h exp continuation of %h", k, eg_d[k], eg_d[k-1]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        port_enable = '1;
        s_tvalid = '0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = '0;
        m_tready = 1'b1;
        eg_n = 0;
        gl_n = 0;
        last_gv = 1'b0;
        for (int i = 0; i < NP; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        repeat (2) @(negedge clock);
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_port_enable();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Round-robin, frame-locked arbiter that shares one AXI-Stream egress between NUM_PORTS AXI-Stream sources, typically fifo_to_axis instances draining per-queue FIFOs.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted.
- Forwards the stream through one registered output stage and reports grant and frame statistics to the control plane.

Parameters:
- DATA_SIZE, 512, tdata width in bits; tkeep width is DATA_SIZE/8.
- NUM_PORTS, 4, number of requesting sources (2..16).
- GRANT_WIDTH, 2, width of grant index; must satisfy 2**GRANT_WIDTH >= NUM_PORTS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- port_enable  in  NUM_PORTS  per-source arbitration enable mask.
- s_tvalid  in  NUM_PORTS  per-source valid.
- s_tready  out  NUM_PORTS  per-source ready.
- s_tdata  in  NUM_PORTS*DATA_SIZE  source i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- s_tkeep  in  NUM_PORTS*DATA_SIZE/8  packed like s_tdata.
- s_tlast  in  NUM_PORTS  per-source end of frame.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- m_tdata  out  DATA_SIZE  egress data.
- m_tkeep  out  DATA_SIZE/8  egress keep.
- m_tlast  out  1  egress end of frame.
- grant_valid  out  1  a source currently holds the grant.
- grant_index  out  GRANT_WIDTH  index of the granted source.
- frame_count  out  32  frames completed on egress; wraps modulo 2**32.

Behaviour:
- The interface uses reset reset, synchronous, active-high, and clock clock.
- Reset values:
  - All outputs are 0: s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, grant_valid, grant_index, frame_count.
  - State is IDLE.
  - last_grant = NUM_PORTS-1, so port 0 has first priority.
- Reset mid-frame drops m_tvalid on the next edge. The partial frame is discarded and no tlast is synthesised.
- Requests:
  - req = s_tvalid & port_enable.
  - Bits of port_enable at or above NUM_PORTS are ignored.
- State IDLE:
  - s_tready = 0 on all ports.
  - If req != 0, select the first set bit scanning upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Register grant_index = selection and grant_valid = 1, then go to TRANSFER.
- State TRANSFER:
  - Only s_tready[grant_index] may be 1. It is asserted when (!m_tvalid || m_tready).
  - All other s_tready bits are 0.
  - A beat is accepted when s_tvalid[g] && s_tready[g]. On acceptance, the output register loads tdata/tkeep/tlast of g and m_tvalid = 1.
  - If m_tready && m_tvalid and no new beat is accepted, m_tvalid goes to 0.
  - On an accepted beat with s_tlast[g] = 1: last_grant <= g, grant_valid <= 0, and the state returns to IDLE in the same edge. The output register still presents that tlast beat.
- frame_count increments by 1 on each egress handshake (m_tvalid && m_tready) with m_tlast = 1.
- Latency and throughput:
  - A source asserting s_tvalid in IDLE gets s_tready one cycle later.
  - The first beat appears on m_tvalid one cycle after acceptance.
  - Steady state is one beat per clock while m_tready = 1.
  - Minimum one idle arbitration cycle between frames.
- Egress rules:
  - m_tdata, m_tkeep and m_tlast hold stable while m_tvalid && !m_tready.
  - m_tvalid never drops without a handshake, except on reset.
- Clearing port_enable[g] mid-frame does not revoke the grant; the frame completes. The port is excluded from later arbitration.
- Source deasserting s_tvalid mid-frame: the grant is held and egress bubbles (m_tvalid = 0 after drain). There is no timeout.
- Single requester: that port is re-granted after each IDLE cycle.
- Requests arriving during TRANSFER are only considered at the next IDLE cycle.

Test Plan:
- Reset, then port 1 sends a 3-beat frame (data 0xA1..0xA3, last on beat 3) with m_tready = 1:
  - grant_index = 1 one cycle after s_tvalid.
  - Egress shows A1, A2, A3 on consecutive cycles, with m_tlast on A3.
  - frame_count = 1.
- Ports 0..3 each hold a 2-beat frame simultaneously:
  - Frames egress in order 0,1,2,3 with no interleaving.
  - grant_index sequence is 0,1,2,3; frame_count = 4.
- Backpressure: m_tready held 0 for 5 cycles mid-frame:
  - m_tdata/m_tlast stay stable.
  - s_tready[g] = 0 while the register is full.
  - No beat is lost or duplicated after release.
- port_enable = 4'b0101 with all ports requesting:
  - Grants alternate 0,2,0,2.
  - Clearing bit 2 during port 2's frame still completes that frame with tlast.
- Assert reset during beat 2 of a 4-beat frame:
  - Next cycle: m_tvalid = 0, grant_valid = 0, frame_count = 0.
  - Next grant goes to port 0.
- Single port 3 sends back-to-back 1-beat frames:
  - One idle cycle between beats.
  - m_tlast set on every beat; frame_count increments per beat.
